parametric_demux_stream: RTL
============================

PARAMETRIC_DEMUX_STREAM -- requirements
Module: parametric_demux_stream

Interface
- REQ-001: Parameter DATA_WIDTH, default 1, sets the width of the data bus on the input and on every output.
- REQ-002: Parameter NUM_OUTPUTS, default 2, sets the number of output streams; legal range is NUM_OUTPUTS >= 2.
- REQ-003: SEL_WIDTH SHALL equal $clog2(NUM_OUTPUTS).
- REQ-004: CLK, input, 1: the single clock; all state updates on its rising edge.
- REQ-005: RST, input, 1: reset, synchronous and active-high.
- REQ-006: VALID_IN, input, 1: the input beat is valid.
- REQ-007: READY_OUT, output, 1: the block accepts the input beat this cycle.
- REQ-008: BUS_IN, input, DATA_WIDTH: input data.
- REQ-009: SEL_IN, input, SEL_WIDTH: destination output index for the input beat.
- REQ-010: VALID_OUT, output, NUM_OUTPUTS: per-output valid, at most one bit set.
- REQ-011: READY_IN, input, NUM_OUTPUTS: per-output ready from the downstream consumers.
- REQ-012: BUS_OUT, output, unpacked array [NUM_OUTPUTS] of DATA_WIDTH: per-output data.
- REQ-013: DROP_OUT, output, 1: one-cycle pulse when an accepted beat is discarded.
- REQ-014: DROP_COUNT_OUT, output, 16: saturating count of discarded beats.

Function
- REQ-015: The block SHALL hold exactly one buffered beat in a holding register with fields full, hdata and hsel.
- REQ-016: An input transfer SHALL occur when VALID_IN and READY_OUT are both high on a rising edge.
- REQ-017: An output transfer on index k SHALL occur when VALID_OUT[k] and READY_IN[k] are both high.
- REQ-018: READY_OUT SHALL be combinational and equal to !RST && (!full || READY_IN[hsel]).
  - Back-to-back beats therefore sustain one beat per cycle while the held destination is ready.
- REQ-019: VALID_OUT[k] SHALL equal full && (hsel == k); all other bits SHALL be 0.
- REQ-020: Every BUS_OUT[k] SHALL carry hdata.
  - Consumers SHALL qualify the data with their own VALID_OUT bit.
- REQ-021: Latency from input transfer to VALID_OUT assertion SHALL be exactly 1 cycle.
- REQ-022: When an output transfer and an input transfer occur in the same cycle, the holding register SHALL load the new beat and full SHALL remain 1.
- REQ-023: When only an output transfer occurs, full SHALL clear on that edge.
- REQ-024: When only an input transfer occurs, full SHALL set on that edge.
- REQ-025: While full and !READY_IN[hsel], hdata, hsel and VALID_OUT SHALL remain stable, and READY_OUT SHALL be 0.
- REQ-026: READY_IN bits of non-selected outputs SHALL have no effect.
- REQ-027: An input transfer with SEL_IN >= NUM_OUTPUTS (possible only when NUM_OUTPUTS is not a power of 2) SHALL be accepted and discarded:
  - the holding register is not loaded;
  - DROP_OUT pulses high for the following cycle;
  - DROP_COUNT_OUT increments by 1.
- REQ-028: When a discarding transfer coincides with an output transfer, full SHALL clear.
- REQ-029: DROP_COUNT_OUT SHALL saturate at 16'hFFFF and never wrap.
- REQ-030: Beat ordering SHALL be preserved per output and globally; no beat SHALL be duplicated or lost except by REQ-027.

Reset
- REQ-031: While RST is high on a rising edge, the block SHALL set full=0, hdata=0, hsel=0, DROP_OUT=0 and DROP_COUNT_OUT=0.
- REQ-032: While RST is high, VALID_OUT SHALL be all-zero and READY_OUT SHALL be 0.
- REQ-033: A beat held when RST rises SHALL be discarded without an output transfer; the first input transfer after RST falls SHALL behave as from empty.

Verification
- REQ-034: Basic route. Setup: DATA_WIDTH=8, NUM_OUTPUTS=4, all READY_IN=1. Stimulus: inject 0x11 sel 2. Response: next cycle VALID_OUT=4'b0100 and BUS_OUT[2]=0x11 for one cycle; VALID_OUT=0 after.
- REQ-035: Back-to-back streaming. Stimulus: inject 0xA0..0xA7 on consecutive cycles with sel cycling 0..3, all ready. Response: READY_OUT stays 1 throughout; outputs receive the beats in order, one per cycle, with 1-cycle latency.
- REQ-036: Backpressure. Stimulus: inject 0x55 sel 1 with READY_IN[1]=0 for 5 cycles, presenting 0x66 sel 0 meanwhile. Response: VALID_OUT=4'b0010 with data stable and READY_OUT=0 for 5 cycles; on READY_IN[1]=1, 0x55 transfers and 0x66 is accepted in the same cycle.
- REQ-037: Out-of-range select. Setup: NUM_OUTPUTS=3. Stimulus: inject sel 3. Response: no VALID_OUT; DROP_OUT pulses once; DROP_COUNT_OUT 0 -> 1. With the count preloaded to 0xFFFF by forcing, a further drop leaves it at 0xFFFF.
- REQ-038: Reset mid-operation. Stimulus: hold 0x77 sel 0 with READY_IN[0]=0, then assert RST for 1 cycle. Response: VALID_OUT=0 and READY_OUT=0 during reset; afterwards empty, DROP_COUNT_OUT=0, and 0x77 is never delivered.

Source files
------------

// File: rtl/parametric_demux_stream.sv
`default_nettype none
// ============================================================================
//  Module      : parametric_demux_stream
//  Description : One-deep buffered valid/ready stream demultiplexer. Each
//                accepted beat is routed to the output named by its select
//                field. Beats with an out-of-range select are swallowed and
//                counted in a saturating 16-bit drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module parametric_demux_stream #(
   parameter  int DATA_WIDTH  = 1,
   parameter  int NUM_OUTPUTS = 2,
   localparam int SEL_WIDTH   = $clog2(NUM_OUTPUTS)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   VALID_IN,
   output logic                   READY_OUT,
   input  logic [DATA_WIDTH-1:0]  BUS_IN,
   input  logic [SEL_WIDTH-1:0]   SEL_IN,
   output logic [NUM_OUTPUTS-1:0] VALID_OUT,
   input  logic [NUM_OUTPUTS-1:0] READY_IN,
   output logic [DATA_WIDTH-1:0]  BUS_OUT [NUM_OUTPUTS],
   output logic                   DROP_OUT,
   output logic [15:0]            DROP_COUNT_OUT
);

   localparam logic [15:0] c_cnt_max = 16'hFFFF;

   // Holding register: the single buffered beat
   logic                  r_full;
   logic [DATA_WIDTH-1:0] r_hdata;
   logic [SEL_WIDTH-1:0]  r_hsel;

   // Discard reporting
   logic                  r_drop;
   logic [15:0]           r_drop_cnt;

   logic                  w_hsel_ready;
   logic                  w_in_xfer;
   logic                  w_out_xfer;
   logic                  w_sel_ok;

   // Pick the ready of the currently held destination; other readies are ignored
   always_comb begin
      w_hsel_ready = 1'b0;
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
         if (r_hsel == SEL_WIDTH'(k)) begin
            w_hsel_ready = READY_IN[k];
         end
      end
   end

   // A select can only be out of range when the output count is not a power of two
   generate
      if ((1 << SEL_WIDTH) == NUM_OUTPUTS) begin : g_sel_pow2
         assign w_sel_ok = 1'b1;
      end else begin : g_sel_range
         assign w_sel_ok = (SEL_IN < SEL_WIDTH'(NUM_OUTPUTS));
      end
   endgenerate

   // Accept whenever the slot is empty or is being drained in this same cycle
   assign READY_OUT  = !RST && (!r_full || w_hsel_ready);
   assign w_out_xfer = r_full && w_hsel_ready;
   assign w_in_xfer  = VALID_IN && READY_OUT;

   // Per-output valid is decoded from the held select; data is broadcast
   generate
      for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_out
         assign VALID_OUT[k] = !RST && r_full && (r_hsel == SEL_WIDTH'(k));
         assign BUS_OUT[k]   = r_hdata;
      end
   endgenerate

   assign DROP_OUT       = r_drop;
   assign DROP_COUNT_OUT = r_drop_cnt;

   // Holding register: load on an in-range accept, otherwise empty on drain
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_full  <= 1'b0;
         r_hdata <= '0;
         r_hsel  <= '0;
      end else if (w_in_xfer && w_sel_ok) begin
         r_full  <= 1'b1;
         r_hdata <= BUS_IN;
         r_hsel  <= SEL_IN;
      end else if (w_out_xfer) begin
         r_full  <= 1'b0;
      end
   end

   // Drop pulse and saturating drop counter for out-of-range accepts
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_drop     <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         r_drop <= w_in_xfer && !w_sel_ok;
         if (w_in_xfer && !w_sel_ok && (r_drop_cnt != c_cnt_max)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end
      end
   end

endmodule
`default_nettype wire
